mem_arbiter: RTL and testbench

Single-port memory arbiter that shares the unified instruction/data memory between the fetch stage (I port) and the load/store stage (D port). It grants one requester at a time, drives the memory port, waits a fixed access latency, and returns read data or write acknowledge to the winner. Data requests win by default. A starvation counter guarantees fetch progress. The block sits between the pipeline and the memory array.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port arbiter sharing one memory between the fetch (I) and load/store (D) ports.
// Data wins contention until the starvation counter forces a fetch grant.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_wmask,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  // Handshake: a requester holds req with stable fields until it sees gnt in
  // the same cycle; the access is consumed on that edge and answered by a
  // single-cycle rvalid pulse MEM_LAT+1 cycles after the grant.

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} own_t;

  localparam logic [2:0] LAT_LAST   = MEM_LAT[2:0];
  localparam logic [3:0] STARVE_TOP = STARVE_MAX[3:0];

  state_t            state, state_nxt;
  logic [2:0]        lat_cnt, lat_cnt_nxt;
  logic [3:0]        starve_cnt, starve_nxt;
  logic [ADDR_W-1:0] addr_q;
  own_t              own_q;
  logic              own_we_q;

  logic grant_i, grant_d, done;

  // Grant decision; grants are suppressed while reset is asserted so that
  // every output reads 0 during reset.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE && rst) begin
      if (d_req && (!i_req || starve_cnt < STARVE_TOP)) grant_d = 1'b1;
      else if (i_req)                                   grant_i = 1'b1;
    end
  end

  assign done = (state == WAIT) && (lat_cnt == LAT_LAST);

  always_comb begin
    i_gnt   = grant_i;
    d_gnt   = grant_d;
    m_req   = grant_i | grant_d;
    m_we    = grant_d & d_we;
    m_wmask = grant_d ? d_wmask : 4'b0000;
    m_wdata = grant_d ? d_wdata : '0;
    if (grant_d)      m_addr = d_addr;
    else if (grant_i) m_addr = i_addr;
    else              m_addr = addr_q;
    busy    = (state == WAIT);
  end

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    case (state)
      IDLE: begin
        if (grant_i || grant_d) begin
          state_nxt   = WAIT;
          lat_cnt_nxt = 3'd1;
        end
      end
      WAIT: begin
        if (done) begin
          state_nxt   = IDLE;
          lat_cnt_nxt = 3'd0;
        end else begin
          lat_cnt_nxt = lat_cnt + 3'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        lat_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Counts D wins against a waiting fetch; any cycle without a fetch request clears it.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!i_req || grant_i)                         starve_nxt = 4'd0;
    else if (grant_d && starve_cnt < STARVE_TOP)   starve_nxt = starve_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lat_cnt    <= 3'd0;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      own_q    <= OWN_I;
      own_we_q <= 1'b0;
    end else if (grant_d) begin
      addr_q   <= d_addr;
      own_q    <= OWN_D;
      own_we_q <= d_we;
    end else if (grant_i) begin
      addr_q   <= i_addr;
      own_q    <= OWN_I;
      own_we_q <= 1'b0;
    end
  end

  // Completion: capture read data for the owner and pulse its rvalid next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= done && (own_q == OWN_I);
      d_rvalid <= done && (own_q == OWN_D);
      if (done && own_q == OWN_I)              i_rdata <= m_rdata;
      if (done && own_q == OWN_D && !own_we_q) d_rdata <= m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one MEM_LAT=1 instance backed by a small
// byte-maskable memory, and one MEM_LAT=3 instance with an address-derived read pattern.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wmask;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, busy;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wmask;

  logic        i_req2, d_req2;
  logic [31:0] d_addr2;
  logic        i_gnt2, i_rvalid2, d_gnt2, d_rvalid2, m_req2, m_we2, busy2;
  logic [31:0] i_rdata2, d_rdata2, m_addr2, m_wdata2, m_rdata2;
  logic [3:0]  m_wmask2;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] mem [0:255];

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_wmask(m_wmask), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req2), .i_addr(i_addr), .i_gnt(i_gnt2), .i_rvalid(i_rvalid2), .i_rdata(i_rdata2),
    .d_req(d_req2), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr2), .d_wdata(d_wdata),
    .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
    .m_req(m_req2), .m_we(m_we2), .m_wmask(m_wmask2), .m_addr(m_addr2), .m_wdata(m_wdata2),
    .m_rdata(m_rdata2), .busy(busy2)
  );

  // m_addr is held through the wait, so a combinational read is valid at T+MEM_LAT.
  assign m_rdata  = mem[m_addr[9:2]];
  assign m_rdata2 = m_addr2 ^ 32'hCAFE0000;

  always @(posedge clk) begin
    if (m_req && m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_wmask[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wmask = 4'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    i_req2 = 1'b0; d_req2 = 1'b0; d_addr2 = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[16] = 32'hAABBCCDD;
    mem[64] = 32'hDEADBEEF;

    #2 rst = 1'b0;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h40;
    repeat (3) begin
      step(); #1;
      chk1("rst_i_gnt", i_gnt, 1'b0);
      chk1("rst_d_gnt", d_gnt, 1'b0);
      chk1("rst_m_req", m_req, 1'b0);
      chk ("rst_m_addr", m_addr, 32'h0);
      chk ("rst_m_wdata", m_wdata, 32'h0);
      chk1("rst_busy", busy, 1'b0);
      chk ("rst_d_rdata", d_rdata, 32'h0);
      chk ("rst_i_rdata", i_rdata, 32'h0);
    end

    // First cycle after release: load 0x40 granted.
    step(); rst = 1'b1; i_req = 1'b0; #1;
    chk1("first_d_gnt", d_gnt, 1'b1);
    chk1("first_i_gnt", i_gnt, 1'b0);
    chk ("first_m_addr", m_addr, 32'h40);
    chk1("first_m_we", m_we, 1'b0);
    step(); d_req = 1'b0; #1;
    chk1("first_busy", busy, 1'b1);
    chk1("first_wait_m_req", m_req, 1'b0);
    chk ("first_wait_m_addr", m_addr, 32'h40);
    step(); #1;
    chk1("first_d_rvalid", d_rvalid, 1'b1);
    chk ("first_d_rdata", d_rdata, 32'hAABBCCDD);
    chk1("first_busy_done", busy, 1'b0);
    step(); #1;
    chk1("first_d_rvalid_pulse", d_rvalid, 1'b0);

    // Single fetch.
    step(); i_req = 1'b1; i_addr = 32'h100; #1;
    chk1("fetch_i_gnt", i_gnt, 1'b1);
    chk1("fetch_d_gnt", d_gnt, 1'b0);
    chk1("fetch_m_req", m_req, 1'b1);
    chk ("fetch_m_addr", m_addr, 32'h100);
    chk ("fetch_m_wmask", {28'd0, m_wmask}, 32'h0);
    step(); i_req = 1'b0; #1;
    chk ("fetch_wait_m_addr", m_addr, 32'h100);
    chk1("fetch_busy", busy, 1'b1);
    chk1("fetch_early_rvalid", i_rvalid, 1'b0);
    step(); #1;
    chk1("fetch_i_rvalid", i_rvalid, 1'b1);
    chk ("fetch_i_rdata", i_rdata, 32'hDEADBEEF);
    step(); #1;
    chk1("fetch_i_rvalid_pulse", i_rvalid, 1'b0);
    chk ("fetch_i_rdata_held", i_rdata, 32'hDEADBEEF);
    chk ("idle_m_addr_hold", m_addr, 32'h100);

    // Masked store then back-to-back load of the same word.
    step(); d_req = 1'b1; d_we = 1'b1; d_wmask = 4'b0011; d_addr = 32'h40; d_wdata = 32'h12345678; #1;
    chk1("st_d_gnt", d_gnt, 1'b1);
    chk1("st_m_we", m_we, 1'b1);
    chk ("st_m_wmask", {28'd0, m_wmask}, 32'h3);
    chk ("st_m_wdata", m_wdata, 32'h12345678);
    chk ("st_m_addr", m_addr, 32'h40);
    step(); d_req = 1'b0; d_we = 1'b0; d_wmask = 4'b0; #1;
    chk1("st_wait_m_we", m_we, 1'b0);
    chk ("st_wait_m_wmask", {28'd0, m_wmask}, 32'h0);
    step(); d_req = 1'b1; #1;
    chk1("st_d_rvalid", d_rvalid, 1'b1);
    chk ("st_d_rdata_unchanged", d_rdata, 32'hAABBCCDD);
    chk1("ld_gnt_same_cycle", d_gnt, 1'b1);
    step(); d_req = 1'b0; #1;
    chk1("ld_rvalid_low", d_rvalid, 1'b0);
    step(); #1;
    chk1("ld_d_rvalid", d_rvalid, 1'b1);
    chk ("ld_d_rdata", d_rdata, 32'hAABB5678);

    // Contention: D,D,D,D,I repeating, one grant every 2 cycles.
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 0) begin
        i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h40;
      end
      #1;
      chk1($sformatf("cont_i_gnt_%0d", k), i_gnt, (k % 10 == 8));
      chk1($sformatf("cont_d_gnt_%0d", k), d_gnt, (k % 2 == 0) && (k % 10 != 8));
    end
    step(); i_req = 1'b0; d_req = 1'b0; #1;
    chk1("cont_last_i_rvalid", i_rvalid, 1'b1);
    chk ("cont_last_i_rdata", i_rdata, 32'hDEADBEEF);
    chk1("cont_no_gnt", d_gnt, 1'b0);

    // MEM_LAT=3 instance.
    step(); d_req2 = 1'b1; d_addr2 = 32'h80; #1;
    chk1("lat3_gnt", d_gnt2, 1'b1);
    chk1("lat3_m_req", m_req2, 1'b1);
    for (int j = 1; j <= 3; j++) begin
      step(); d_addr2 = 32'hC0; #1;
      chk1($sformatf("lat3_busy_%0d", j), busy2, 1'b1);
      chk1($sformatf("lat3_no_gnt_%0d", j), d_gnt2, 1'b0);
      chk1($sformatf("lat3_no_rvalid_%0d", j), d_rvalid2, 1'b0);
      chk ($sformatf("lat3_m_addr_%0d", j), m_addr2, 32'h80);
    end
    step(); #1;
    chk1("lat3_rvalid", d_rvalid2, 1'b1);
    chk ("lat3_rdata", d_rdata2, 32'hCAFE0080);
    chk1("lat3_busy_done", busy2, 1'b0);
    chk1("lat3_second_gnt", d_gnt2, 1'b1);
    step(); d_req2 = 1'b0; #1;
    chk1("lat3_rvalid_pulse", d_rvalid2, 1'b0);
    chk1("lat3_busy_again", busy2, 1'b1);
    repeat (2) step();
    step(); #1;
    chk1("lat3_second_rvalid", d_rvalid2, 1'b1);
    chk ("lat3_second_rdata", d_rdata2, 32'hCAFE00C0);

    // Reset in the middle of a load.
    step(); d_req = 1'b1; d_addr = 32'h100; #1;
    chk1("mid_gnt", d_gnt, 1'b1);
    step(); rst = 1'b0; d_req = 1'b0; #1;
    chk1("mid_busy", busy, 1'b0);
    chk1("mid_rvalid", d_rvalid, 1'b0);
    chk ("mid_d_rdata", d_rdata, 32'h0);
    step(); #1;
    chk1("mid_rvalid_rst", d_rvalid, 1'b0);
    rst = 1'b1;
    step(); #1;
    chk1("mid_rvalid_after", d_rvalid, 1'b0);
    chk1("mid_busy_after", busy, 1'b0);
    step(); d_req = 1'b1; d_addr = 32'h40; #1;
    chk1("post_gnt", d_gnt, 1'b1);
    step(); d_req = 1'b0;
    step(); #1;
    chk1("post_rvalid", d_rvalid, 1'b1);
    chk ("post_rdata", d_rdata, 32'hAABB5678);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
